mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 32-bit image memory between the PC transfer controller (port A) and the image-processing engine (port B).
- Per-cycle round-robin arbitration, optional burst locking with a bounded lock length, and read-return tagging so each requester gets a `rvalid` aligned to the memory read latency.
- Sits between both masters and the memory's `mem_en`/`mem_we`/`mem_addr`/`mem_dw`/`mem_dr` port.

Parameters:
- MEMORY_ADDR_SIZE, 16, address width of the memory word port.
- MEM_LATENCY, 1, cycles from enabled read to valid `mem_dr` (1..4).
- LOCK_MAX, 64, maximum consecutive granted cycles for a locked owner while the other port waits (2..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A access request (held until granted).
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_lock  in  1  port A requests to keep ownership for following cycles.
- a_addr  in  MEMORY_ADDR_SIZE  port A word address.
- a_dw  in  32  port A write data.
- a_gnt  out  1  port A access accepted this cycle (combinational).
- a_rvalid  out  1  `a_rdata` holds port A read data.
- a_rdata  out  32  read data (equals `mem_dr`).
- b_req, b_we, b_lock, b_addr, b_dw, b_gnt, b_rvalid, b_rdata: same as the port A signals, for port B.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEMORY_ADDR_SIZE  memory address.
- mem_dw  out  32  memory write data.
- mem_dr  in  32  memory read data.

Behaviour:
- Registered state:
  - `ready`: 0 in reset, set on the first clock edge after reset deasserts.
  - `last`: last granted port; reset value B, so A wins the first tie.
  - `locked`.
  - `owner`.
  - `lock_cnt`: 8 bit.
  - `rd_pipe`: MEM_LATENCY stages of {valid, port}.
- Reset values: all registers cleared as listed; `a_gnt` = `b_gnt` = `a_rvalid` = `b_rvalid` = `mem_en` = `mem_we` = 0; `mem_addr` = `mem_dw` = 0.
- While `ready` = 0, no grants are issued.
- Grant decision is combinational each cycle; at most one of `a_gnt`/`b_gnt` is high. Evaluate in this order:
  1. `locked` and the owner's req = 1 and the owner's lock = 1:
     - If `lock_cnt` < LOCK_MAX, grant the owner.
     - If `lock_cnt` = LOCK_MAX and the other port is requesting, grant the other port (lock break).
     - If `lock_cnt` = LOCK_MAX and the other port is idle, grant the owner.
  2. Only one port requesting: grant it.
  3. Both requesting: grant the port that is not `last`.
  4. Neither requesting: no grant; `mem_en` = 0.
- Granted port's we/addr/dw drive `mem_we`/`mem_addr`/`mem_dw`, and `mem_en` = 1.
- When there is no grant, `mem_addr`/`mem_dw` hold 0 and `mem_we` = 0.
- Lock tracking, on the clock edge:
  - Grant to X with X's lock = 1:
    - If not already locked by X: `locked` <= 1, `owner` <= X, `lock_cnt` <= 1.
    - Else: `lock_cnt` <= min(`lock_cnt` + 1, LOCK_MAX).
  - Grant with lock = 0, a lock break, or owner's req dropping: `locked` <= 0, `lock_cnt` <= 0.
  - `last` <= granted port on every grant.
- Lock break:
  - The broken owner does not regain the lock until the other port has been granted once.
  - It re-enters lock normally on its next grant with lock = 1.
- Reads:
  - A granted read (we = 0) enters `rd_pipe` stage 0 tagged with the port.
  - X_rvalid = 1 exactly MEM_LATENCY cycles after the grant edge, for one cycle.
  - Back-to-back reads give back-to-back rvalid in grant order, with mixed ports allowed.
  - Writes produce no rvalid.
- `a_rdata` = `b_rdata` = `mem_dr` at all times; only rvalid qualifies the data.
- Requesters must hold req/we/addr/dw stable until gnt; gnt is same-cycle, so a port requesting every cycle can be granted every cycle.
- Reset asserted mid-operation: in-flight reads are dropped (no rvalid), the lock is cleared, and outputs go to reset values asynchronously.
- Simultaneous lock request from both ports in a tie: the round-robin winner takes the lock; the other waits for the release or break.

Test Plan:
- Reset release, A and B requesting reads at addresses 0x0010/0x6300 every cycle (MEM_LATENCY = 1, no lock) -> grants alternate A, B, A, B; `a_rvalid` and `b_rvalid` alternate one cycle after each grant with `mem_dr` passed through.
- A alone writes 0x11223344 to address 25343 -> `a_gnt` = 1 the same cycle, `mem_en` = `mem_we` = 1, `mem_addr` = 25343, `mem_dw` = 0x11223344, no rvalid.
- LOCK_MAX = 4, B locked reads continuously, A requests from cycle 2 -> B granted 4 consecutive cycles, then A granted once, then B regains.
- Locked owner A drops lock after 3 grants while B requesting -> B is granted the next cycle; `lock_cnt` = 0.
- MEM_LATENCY = 3, reads A, B, A granted in consecutive cycles -> `a_rvalid`, `b_rvalid`, `a_rvalid` in consecutive cycles starting 3 cycles after the first grant.
- Reset asserted one cycle after a granted read -> no rvalid ever appears; both gnt = 0 until one cycle after reset deasserts.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared image memory, with bounded burst locking and read-return tagging.
// Ports: clk/reset, A and B requester ports (req/we/lock/addr/dw, gnt/rvalid/rdata), memory port mem_*.
module mem_arbiter #(
  parameter int MEMORY_ADDR_SIZE = 16,
  parameter int MEM_LATENCY      = 1,
  parameter int LOCK_MAX         = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_req,
  input  logic                        a_we,
  input  logic                        a_lock,
  input  logic [MEMORY_ADDR_SIZE-1:0] a_addr,
  input  logic [31:0]                 a_dw,
  output logic                        a_gnt,
  output logic                        a_rvalid,
  output logic [31:0]                 a_rdata,
  input  logic                        b_req,
  input  logic                        b_we,
  input  logic                        b_lock,
  input  logic [MEMORY_ADDR_SIZE-1:0] b_addr,
  input  logic [31:0]                 b_dw,
  output logic                        b_gnt,
  output logic                        b_rvalid,
  output logic [31:0]                 b_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  output logic [31:0]                 mem_dw,
  input  logic [31:0]                 mem_dr
);

  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  logic                   ready;
  logic                   locked;
  port_t                  last;
  port_t                  owner;
  logic [7:0]             lock_cnt;
  logic [MEM_LATENCY-1:0] pv;
  logic [MEM_LATENCY-1:0] pp;

  logic  own_req;
  logic  own_lock;
  logic  oth_req;
  logic  brk;
  logic  g_lock;
  port_t g_port;

  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    brk      = 1'b0;
    own_req  = (owner == PORT_A) ? a_req  : b_req;
    own_lock = (owner == PORT_A) ? a_lock : b_lock;
    oth_req  = (owner == PORT_A) ? b_req  : a_req;
    if (!ready) begin
      a_gnt = 1'b0;
    end else if (locked && own_req && own_lock) begin
      // Saturated lock yields only when the other side is waiting.
      if (lock_cnt < LMAX || !oth_req) begin
        a_gnt = (owner == PORT_A);
        b_gnt = (owner == PORT_B);
      end else begin
        brk   = 1'b1;
        a_gnt = (owner == PORT_B);
        b_gnt = (owner == PORT_A);
      end
    end else if (a_req && b_req) begin
      a_gnt = (last == PORT_B);
      b_gnt = (last == PORT_A);
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  always_comb begin
    mem_en   = a_gnt | b_gnt;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dw   = '0;
    g_lock   = 1'b0;
    g_port   = b_gnt ? PORT_B : PORT_A;
    unique case (1'b1)
      a_gnt: begin
        mem_we   = a_we;
        mem_addr = a_addr;
        mem_dw   = a_dw;
        g_lock   = a_lock;
      end
      b_gnt: begin
        mem_we   = b_we;
        mem_addr = b_addr;
        mem_dw   = b_dw;
        g_lock   = b_lock;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready    <= 1'b0;
      locked   <= 1'b0;
      last     <= PORT_B;
      owner    <= PORT_A;
      lock_cnt <= 8'd0;
      pv       <= '0;
      pp       <= '0;
    end else begin
      ready <= 1'b1;
      if (mem_en) last <= g_port;
      if (mem_en && g_lock && !brk) begin
        if (locked && owner == g_port) begin
          lock_cnt <= (lock_cnt >= LMAX) ? LMAX : lock_cnt + 8'd1;
        end else begin
          locked   <= 1'b1;
          owner    <= g_port;
          lock_cnt <= 8'd1;
        end
      end else begin
        locked   <= 1'b0;
        lock_cnt <= 8'd0;
      end
      // pp tags each in-flight read with its port (1 = B).
      pv[0] <= mem_en & ~mem_we;
      pp[0] <= b_gnt;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
      end
    end
  end

  assign a_rvalid = pv[MEM_LATENCY-1] & ~pp[MEM_LATENCY-1];
  assign b_rvalid = pv[MEM_LATENCY-1] &  pp[MEM_LATENCY-1];
  assign a_rdata  = mem_dr;
  assign b_rdata  = mem_dr;

endmodule
